serial_tx_engine: RTL and testbench

//  Transmit half of the serial block; sits beside the RX top under the serial top.

---
 rtl/serial_tx_engine.sv | 105 ++++++++++
 tb/tb_serial_tx_engine.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/serial_tx_engine.sv
// Serial transmitter: mode 0 synchronous shift (data on RXD, clock on TXD)
// and mode 2 9-bit asynchronous frames on TXD, all paced by the baud tick.
module serial_tx_engine #(
    parameter int DATA_W = 8
) (
    input  logic              serial_clock_i,
    input  logic              serial_reset_i_b,
    input  logic              serial_br_i,
    input  logic              serial_scon7_sm0_i,
    input  logic              serial_scon3_tb8_i,
    input  logic [DATA_W-1:0] serial_sbuf_tx_i,
    input  logic              serial_write_sbuf_i,
    output logic              serial_txd_o,
    output logic              serial_rxd_data_o,
    output logic              serial_p3en_0_o,
    output logic              serial_p3en_1_o,
    output logic              serial_scon1_ti_o,
    output logic              serial_transmit_o
);

    localparam int CNT_W = $clog2(DATA_W + 2);

    typedef enum logic [2:0] {
        IDLE, ARM, M0_LO, M0_HI, START, DATA, NINTH, STOP
    } state_t;

    state_t             state, state_nx;
    logic [DATA_W-1:0]  shreg;
    logic [CNT_W-1:0]   cnt;
    logic               tb8_q;
    logic               mode_q;
    logic               ti_q;
    logic               load;
    logic               last_bit;
    logic               frame_end;

    assign load      = (state == IDLE) && serial_write_sbuf_i;
    assign last_bit  = (cnt == CNT_W'(DATA_W - 1));
    assign frame_end = serial_br_i && ((state == STOP) || (state == M0_HI && last_bit));

    always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
        if (!serial_reset_i_b) state <= IDLE;
        else                   state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (serial_write_sbuf_i) state_nx = ARM;
            ARM:     if (serial_br_i) state_nx = mode_q ? START : M0_LO;
            START:   if (serial_br_i) state_nx = DATA;
            DATA:    if (serial_br_i && last_bit) state_nx = NINTH;
            NINTH:   if (serial_br_i) state_nx = STOP;
            STOP:    if (serial_br_i) state_nx = IDLE;
            M0_LO:   if (serial_br_i) state_nx = M0_HI;
            M0_HI:   if (serial_br_i) state_nx = last_bit ? IDLE : M0_LO;
            default: state_nx = IDLE;
        endcase
    end

    // Frame parameters are frozen at load; later SBUF/SCON writes cannot disturb a frame.
    always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
        if (!serial_reset_i_b) begin
            shreg  <= '0;
            cnt    <= '0;
            tb8_q  <= 1'b0;
            mode_q <= 1'b0;
            ti_q   <= 1'b0;
        end else begin
            ti_q <= frame_end;
            if (load) begin
                shreg  <= serial_sbuf_tx_i;
                tb8_q  <= serial_scon3_tb8_i;
                mode_q <= serial_scon7_sm0_i;
            end else if (serial_br_i) begin
                if (state == ARM) cnt <= '0;
                if (state == DATA || state == M0_HI) begin
                    shreg <= shreg >> 1;
                    if (cnt != CNT_W'(DATA_W + 1)) cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        serial_txd_o      = 1'b1;
        serial_rxd_data_o = 1'b1;
        case (state)
            START:   serial_txd_o = 1'b0;
            DATA:    serial_txd_o = shreg[0];
            NINTH:   serial_txd_o = tb8_q;
            M0_LO: begin
                serial_txd_o      = 1'b0;
                serial_rxd_data_o = shreg[0];
            end
            M0_HI:   serial_rxd_data_o = shreg[0];
            default: ;
        endcase
        serial_transmit_o = (state != IDLE);
        serial_p3en_1_o   = (state != IDLE);
        serial_p3en_0_o   = (state != IDLE) && !mode_q;
        serial_scon1_ti_o = ti_q;
    end

endmodule

// File: tb/tb_serial_tx_engine.sv
// Bench for serial_tx_engine: random bit rates and frames checked per cycle
// against the expected pin waveform derived from the frame bit list.
module tb_serial_tx_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       br = 1'b0;
    logic       sm0 = 1'b0;
    logic       tb8 = 1'b0;
    logic [7:0] sbuf = 8'h00;
    logic       wr = 1'b0;
    logic       txd, rxd, p0, p1, ti, busy;
    logic [5:0] obs;

    int checks = 0;
    int failures = 0;
    int period = 3;
    int br_cnt = 0;

    serial_tx_engine #(.DATA_W(8)) dut (
        .serial_clock_i      (clk),
        .serial_reset_i_b    (rst_n),
        .serial_br_i         (br),
        .serial_scon7_sm0_i  (sm0),
        .serial_scon3_tb8_i  (tb8),
        .serial_sbuf_tx_i    (sbuf),
        .serial_write_sbuf_i (wr),
        .serial_txd_o        (txd),
        .serial_rxd_data_o   (rxd),
        .serial_p3en_0_o     (p0),
        .serial_p3en_1_o     (p1),
        .serial_scon1_ti_o   (ti),
        .serial_transmit_o   (busy)
    );

    always #5 clk = ~clk;

    // {txd, rxd, ti, transmit, p3en_1, p3en_0}
    assign obs = {txd, rxd, ti, busy, p1, p0};

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // One clock; outputs are sampled 1ns after the edge, then next br is set up.
    task automatic cyc();
        @(posedge clk);
        #1;
        br = (br_cnt == 0);
        br_cnt = (br_cnt + 1 >= period) ? 0 : br_cnt + 1;
    endtask

    // Pin values for bit time k of a frame, straight from the frame definition.
    function automatic logic [1:0] pins(input bit m2, input logic [7:0] d, input bit t8, input int k);
        logic [10:0] frame;
        if (m2) begin
            frame = {1'b1, t8, d, 1'b0};
            return {frame[k], 1'b1};
        end
        return {(k % 2 == 1), d[k / 2]};
    endfunction

    task automatic run_frame(input string tag, input bit m2, input logic [7:0] d, input bit t8,
                             input int wr_tick, input int rst_tick, input bit tog,
                             input bit b2b, input bit nm2, input logic [7:0] nd, input bit nt8);
        int  tick = 0;
        int  guard = 0;
        int  nbits;
        bit  done = 0;
        bit  ebr;
        logic [1:0] e;
        nbits = m2 ? 11 : 16;
        sm0 = m2; tb8 = t8; sbuf = d; wr = 1'b1;
        cyc();
        wr = 1'b0;
        while (!done && guard < 300) begin
            guard++;
            if (tick == rst_tick) begin
                rst_n = 1'b0;
                #1;
                chk({tag, "_rst_abort"}, obs, 6'b110000);
                cyc();
                chk({tag, "_rst_hold"}, obs, 6'b110000);
                rst_n = 1'b1;
                return;
            end
            if (tick == 0)
                chk({tag, "_arm"}, obs, {2'b11, 3'b011, !m2});
            else if (tick <= nbits) begin
                e = pins(m2, d, t8, tick - 1);
                chk({tag, "_bit"}, obs, {e, 3'b011, !m2});
            end else begin
                chk({tag, "_end"}, obs, 6'b111000);
                done = 1;
            end
            if (!done) begin
                if (tick == wr_tick) begin
                    wr = 1'b1;
                    sbuf = 8'($urandom);
                end
                if (tog) sm0 = ~sm0;
                ebr = br;
                cyc();
                wr = 1'b0;
                if (ebr) tick++;
            end
        end
        checks++;
        assert (done) else begin
            failures++;
            $error("FAIL %s_timeout observed=%0d expected=%0d ticks", tag, tick, nbits + 1);
        end
        if (b2b) begin
            // Write lands on the ti_o cycle; the next run_frame repeats the same write values.
            sm0 = nm2; tb8 = nt8; sbuf = nd;
            return;
        end
        for (int i = 0; i < 3 * period + 3; i++) begin
            cyc();
            chk({tag, "_idle"}, obs, 6'b110000);
        end
    endtask

    initial begin
        #2;
        chk("reset_state", obs, 6'b110000);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_reset_idle", obs, 6'b110000);

        period = $urandom_range(1, 5);
        run_frame("t1_m2_a5", 1, 8'hA5, 1, -1, -1, 0, 0, 0, 8'h00, 0);
        period = $urandom_range(2, 5);
        run_frame("t2_m0_3c", 0, 8'h3C, 0, -1, -1, 0, 0, 0, 8'h00, 0);
        period = $urandom_range(1, 5);
        run_frame("t3_busy_wr", 1, 8'h55, 0, 6, -1, 0, 0, 0, 8'h00, 0);
        period = $urandom_range(1, 5);
        run_frame("t4_first", 1, 8'h0F, 0, -1, -1, 0, 1, 1, 8'hF0, 1);
        run_frame("t4_second", 1, 8'hF0, 1, -1, -1, 0, 0, 0, 8'h00, 0);
        period = $urandom_range(1, 5);
        run_frame("t5_reset", 1, 8'h96, 1, -1, 5, 0, 0, 0, 8'h00, 0);
        run_frame("t5_clean", 1, 8'h96, 1, -1, -1, 0, 0, 0, 8'h00, 0);
        period = $urandom_range(1, 5);
        run_frame("t6_sm0_tog", 1, 8'hC3, 0, -1, -1, 1, 0, 0, 8'h00, 0);
        period = $urandom_range(1, 5);
        run_frame("m0_b2b_first", 0, 8'h81, 0, -1, -1, 0, 1, 0, 8'h7E, 0);
        run_frame("m0_b2b_second", 0, 8'h7E, 0, -1, -1, 0, 0, 0, 8'h00, 0);

        for (int n = 0; n < 8; n++) begin
            period = $urandom_range(1, 6);
            run_frame("rand", 1'($urandom), 8'($urandom), 1'($urandom),
                      $urandom_range(0, 14), -1, 1'($urandom), 0, 0, 8'h00, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
